// File: rtl/ldo_trim_seq.sv
// ldo_trim_seq: Wishbone-controlled one-hot LDO trim ramp sequencer.
// Define LDO_TRIM_IRQ_EN to build the done/IRQMASK/irq_o logic.
module ldo_trim_seq #(
  parameter int NCH      = 3,
  parameter int TRIM_W   = 16,
  parameter int RST_IDX  = 8,
  parameter int STEP_DIV = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NCH*TRIM_W-1:0] trim_o,
  output logic                  irq_o
);
  localparam int IW = $clog2(TRIM_W);
  localparam logic [IW-1:0] RST_I = IW'(RST_IDX);
  localparam logic [IW-1:0] MAX_I = IW'(TRIM_W - 1);

  logic [NCH-1:0] en;
  logic [IW-1:0]  target [NCH];
  logic [IW-1:0]  cur [NCH];
  logic [IW-1:0]  nxt [NCH];
  logic [15:0]    step, pre, step_m1;
  logic [NCH-1:0] busy, done, mask, hit_done;
  logic           req, wr, tick, ch_hit, step_wr;
  logic [7:0]     a;
  logic [3:0]     ch_idx;
  logic [IW-1:0]  wtgt;
  logic [31:0]    rdata;
  logic           unused;

  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign a       = wbs_adr_i[7:0];
  assign ch_idx  = a[5:2];
  assign ch_hit  = (a[7:6] == 2'b00) && (a[1:0] == 2'b00)
                && ({28'b0, ch_idx} < 32'(NCH));
  assign step_wr = wr && (a == 8'h44);
  assign wtgt    = (wbs_dat_i[7:0] >= 8'(TRIM_W)) ? MAX_I
                                                  : wbs_dat_i[IW-1:0];
  assign step_m1 = (step == 16'd0) ? 16'd0 : step - 16'd1;
  assign tick    = (pre >= step_m1);
  assign unused  = ^{wbs_adr_i[31:8], wbs_dat_i, wbs_sel_i, hit_done};

  always_comb begin
    busy     = '0;
    hit_done = '0;
    for (int c = 0; c < NCH; c++) begin
      nxt[c] = cur[c];
      if (cur[c] < target[c])      nxt[c] = cur[c] + IW'(1);
      else if (cur[c] > target[c]) nxt[c] = cur[c] - IW'(1);
      busy[c]     = en[c] && (cur[c] != target[c]);
      hit_done[c] = tick && busy[c] && (nxt[c] == target[c]);
    end
  end

  always_comb begin
    rdata = '0;
    if (ch_hit) begin
      for (int c = 0; c < NCH; c++)
        if (ch_idx == 4'(c))
          rdata = {23'b0, en[c], 8'(target[c])};
    end else if (a == 8'h40) begin
      rdata[NCH-1:0]  = busy;
      rdata[16 +: NCH] = done;
    end else if (a == 8'h44) begin
      rdata[15:0] = step;
    end else if (a == 8'h48) begin
      rdata[NCH-1:0] = mask;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      step      <= 16'(STEP_DIV);
      pre       <= '0;
      en        <= '0;
      trim_o    <= '0;
      for (int c = 0; c < NCH; c++) begin
        target[c] <= RST_I;
        cur[c]    <= RST_I;
      end
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      if (step_wr || tick) pre <= '0;
      else                 pre <= pre + 16'd1;
      if (step_wr && wbs_sel_i[0]) step[7:0]  <= wbs_dat_i[7:0];
      if (step_wr && wbs_sel_i[1]) step[15:8] <= wbs_dat_i[15:8];
      for (int c = 0; c < NCH; c++) begin
        if (wr && ch_hit && ch_idx == 4'(c)) begin
          if (wbs_sel_i[0]) target[c] <= wtgt;
          if (wbs_sel_i[1]) en[c]     <= wbs_dat_i[8];
        end
        // disabled channels park at the reset index so re-enable ramps from it
        if (!en[c])    cur[c] <= RST_I;
        else if (tick) cur[c] <= nxt[c];
        trim_o[c*TRIM_W +: TRIM_W] <= en[c] ? (TRIM_W'(1) << cur[c]) : '0;
      end
    end
  end

`ifdef LDO_TRIM_IRQ_EN
  logic [NCH-1:0] w1c;
  assign w1c = (wr && a == 8'h40 && wbs_sel_i[2]) ? wbs_dat_i[16 +: NCH] : '0;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      done  <= '0;
      mask  <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr && a == 8'h48 && wbs_sel_i[0]) mask <= wbs_dat_i[NCH-1:0];
      done  <= (done & ~w1c) | hit_done;
      irq_o <= |(done & mask);
    end
  end
`else
  assign done  = '0;
  assign mask  = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ldo_trim_seq.sv
// tb_ldo_trim_seq: register table plus ramp, irq and reset sequences.
// Expectations follow the build's LDO_TRIM_IRQ_EN setting.
`timescale 1ns/1ps
module tb_ldo_trim_seq;
  localparam int NCH = 3;
  localparam int TW  = 16;
`ifdef LDO_TRIM_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, irq;
  logic [31:0] rdat;
  logic [NCH*TW-1:0] trim;
  int pass_cnt = 0, total = 0;
  logic [15:0] seen[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  ldo_trim_seq dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .trim_o(trim), .irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h want %08h", name, act, exp);
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 4);
    q = rdat;
    if (!ack) begin
      total++;
      $display("FAIL bus_timeout: adr %08h got no ack", a);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] q;
    bus(1'b1, a, d, s, q);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] q;
    bus(1'b0, a, '0, 4'hF, q);
    check(name, q, exp);
  endtask

  task automatic track(input int ch, input logic [15:0] stop,
                       input int budget);
    logic [15:0] v, last;
    seen.delete();
    last = '0;
    for (int i = 0; i < budget; i++) begin
      v = trim[ch*TW +: TW];
      if (v !== '0 && v !== last) seen.push_back(v);
      last = v;
      if (v === stop) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic seq_chk(input string name, input logic [15:0] e[6],
                         input int n);
    check({name, "_len"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check(name, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
            32'(e[i]));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ea[6];
    logic [31:0] q;

    tbl[0]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h8};
    tbl[1]  = '{1'b0, 32'h44, 32'h0,         4'hF, 32'h100};
    tbl[2]  = '{1'b0, 32'h04, 32'h0,         4'hF, 32'h8};
    tbl[3]  = '{1'b0, 32'h40, 32'h0,         4'hF, 32'h0};
    tbl[4]  = '{1'b0, 32'h4C, 32'h0,         4'hF, 32'h0};
    tbl[5]  = '{1'b0, 32'h0C, 32'h0,         4'hF, 32'h0};
    tbl[6]  = '{1'b1, 32'h44, 32'h0000_1234, 4'h1, 32'h134};
    tbl[7]  = '{1'b1, 32'h44, 32'hABCD_5600, 4'h2, 32'h5634};
    tbl[8]  = '{1'b1, 32'h00, 32'h14,        4'h1, 32'hF};
    tbl[9]  = '{1'b1, 32'h00, 32'h03,        4'h1, 32'h3};
    tbl[10] = '{1'b1, 32'h4C, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[11] = '{1'b1, 32'h08, 32'h0000_FF0A, 4'h1, 32'hA};
    tbl[12] = '{1'b0, 32'h100, 32'h0,        4'hF, 32'h3};
    tbl[13] = '{1'b1, 32'h48, 32'hFF,        4'h1, IRQ ? 32'h7 : 32'h0};
    tbl[14] = '{1'b1, 32'h48, 32'h00,        4'h1, 32'h0};
    tbl[15] = '{1'b1, 32'h04, 32'h0000_010F, 4'hC, 32'h8};
    tbl[16] = '{1'b1, 32'h04, 32'h0000_0105, 4'h2, 32'h108};
    tbl[17] = '{1'b1, 32'h04, 32'h0000_0008, 4'h2, 32'h8};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_trim", 32'(trim), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;

    // held strobe: ack every other cycle, data zero while ack low
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h44; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("b2b_ack", 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("b2b_dat", rdat, (i % 2 == 0) ? 32'h100 : 32'h0);
    end
    stb = 1'b0; cyc = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].we) wr(tbl[i].adr, tbl[i].d, tbl[i].s);
      rd_chk($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].exp);
    end

    // upward ramp on channel 1, tick every cycle
    wr(32'h44, 32'h1, 4'h3);
    wr(32'h04, 32'h10C, 4'h3);
    track(1, 16'h1000, 20);
    ea = '{16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h0};
    seq_chk("ramp_up", ea, 5);
    rd_chk("status_a", 32'h40, IRQ ? 32'h0002_0000 : 32'h0);

    // reversal mid-ramp on channel 0 with a slow prescaler
    wr(32'h44, 32'd20, 4'h3);
    wr(32'h00, 32'h10F, 4'h3);
    for (int i = 0; i < 200; i++) begin
      if (trim[15:0] === 16'h0400) break;
      @(posedge clk); #1;
    end
    check("reach_10", 32'(trim[15:0]), 32'h0400);
    rd_chk("status_busy", 32'h40, IRQ ? 32'h0002_0001 : 32'h1);
    wr(32'h00, 32'h105, 4'h3);
    track(0, 16'h0020, 200);
    ea = '{16'h0400, 16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020};
    seq_chk("reverse", ea, 6);
    rd_chk("status_b", 32'h40, IRQ ? 32'h0003_0000 : 32'h0);

    // disable drops trim next cycle; re-enable starts at reset index
    wr(32'h00, 32'h005, 4'h3);
    @(posedge clk); #1;
    check("dis_trim", 32'(trim[15:0]), 32'h0);
    wr(32'h00, 32'h108, 4'h3);
    @(posedge clk); #1;
    check("reen_trim", 32'(trim[15:0]), 32'h0100);
    rd_chk("reen_ch0", 32'h00, 32'h108);

    // interrupt on channel 2 completion and W1C
    wr(32'h44, 32'h1, 4'h3);
    wr(32'h48, 32'h4, 4'h1);
    @(posedge clk); #1;
    check("irq_pre", 32'(irq), 32'h0);
    wr(32'h08, 32'h10A, 4'h3);
    for (int i = 0; i < 20; i++) begin
      if (irq) break;
      @(posedge clk); #1;
    end
    check("irq_set", 32'(irq), 32'(IRQ));
    wr(32'h40, 32'h0004_0000, 4'h4);
    @(posedge clk); #1;
    check("irq_clr", 32'(irq), 32'h0);
    rd_chk("status_d", 32'h40, IRQ ? 32'h0003_0000 : 32'h0);

    // reset during a write ack and mid-ramp
    wr(32'h04, 32'h100, 4'h3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h44; wdat = 32'h55; sel = 4'h3;
    @(posedge clk); #1;
    check("rst_wr_ack", 32'(ack), 32'h1);
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("rst2_ack", 32'(ack), 32'h0);
    check("rst2_dat", rdat, 32'h0);
    check("rst2_trim", 32'(trim), 32'h0);
    check("rst2_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    rd_chk("rst2_ch0", 32'h00, 32'h8);
    rd_chk("rst2_ch1", 32'h04, 32'h8);
    rd_chk("rst2_ch2", 32'h08, 32'h8);
    rd_chk("rst2_step", 32'h44, 32'h100);
    rd_chk("rst2_stat", 32'h40, 32'h0);
    rd_chk("rst2_mask", 32'h48, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst2_trim_hold", 32'(trim), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
